// File: rtl/asmi_arbiter_if.sv
// Bus bundle between the two flash clients, the arbiter and the ASMI megafunction.
// The slave view belongs to the arbiter; the master view drives the clients and the ASMI busy flag.
interface asmi_arbiter_if;
  logic [1:0]  req;
  logic [23:0] c0_addr;
  logic [23:0] c1_addr;
  logic [5:0]  c0_cmd;
  logic [5:0]  c1_cmd;
  logic [7:0]  c0_datain;
  logic        asmi_busy;
  logic [23:0] asmi_addr;
  logic [5:0]  asmi_cmd;
  logic [7:0]  asmi_datain;
  logic [1:0]  gnt;
  logic [1:0]  timeout_err;

  modport slave (
    input  req, c0_addr, c1_addr, c0_cmd, c1_cmd, c0_datain, asmi_busy,
    output asmi_addr, asmi_cmd, asmi_datain, gnt, timeout_err
  );

  modport master (
    output req, c0_addr, c1_addr, c0_cmd, c1_cmd, c0_datain, asmi_busy,
    input  asmi_addr, asmi_cmd, asmi_datain, gnt, timeout_err
  );
endinterface

// File: rtl/asmi_arbiter.sv
// Two-client ownership arbiter for the ASMI flash port: round-robin grant, idle-owner
// revoke with timeout pulse, and a settle window after release before the next grant.
module asmi_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 25000000,
  parameter int unsigned SETTLE_CYCLES  = 2
) (
  input  logic           clock,
  input  logic           reset_n,
  asmi_arbiter_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, OWN0, OWN1, DRAIN} state_t;

  localparam logic [24:0] IDLE_LAST = 25'(TIMEOUT_CYCLES - 1);

  state_t      state_q, state_d;
  logic [24:0] idle_q, idle_d;
  logic [15:0] settle_q, settle_d;
  logic        last_q, last_d;
  logic [1:0]  revoked_q, revoked_d;
  logic [1:0]  tmo_q, tmo_d;
  logic [1:0]  gnt_q, gnt_d;

  logic [1:0]  elig;
  logic        own1;
  logic        own_req;
  logic        own_active;
  logic [5:0]  own_cmd;

  function automatic logic [24:0] sat_inc25(input logic [24:0] v);
    return (&v) ? v : v + 25'd1;
  endfunction

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (&v) ? v : v + 16'd1;
  endfunction

  assign elig       = bus.req & ~revoked_q;
  assign own1       = (state_q == OWN1);
  assign own_cmd    = own1 ? bus.c1_cmd : bus.c0_cmd;
  assign own_req    = own1 ? bus.req[1] : bus.req[0];
  assign own_active = bus.asmi_busy | (|own_cmd);

  always_comb begin
    state_d   = state_q;
    idle_d    = '0;
    settle_d  = '0;
    last_d    = last_q;
    revoked_d = revoked_q & bus.req;
    tmo_d     = '0;
    case (state_q)
      IDLE: begin
        if (elig == 2'b01 || (elig == 2'b11 && last_q)) begin
          state_d = OWN0;
          last_d  = 1'b0;
        end else if (elig != 2'b00) begin
          state_d = OWN1;
          last_d  = 1'b1;
        end
      end
      OWN0, OWN1: begin
        idle_d = own_active ? '0 : sat_inc25(idle_q);
        // A release in the timeout cycle wins: no pulse, no revoke.
        if (!own_req) begin
          state_d = DRAIN;
        end else if (!own_active && idle_q >= IDLE_LAST) begin
          state_d   = DRAIN;
          tmo_d     = own1 ? 2'b10 : 2'b01;
          revoked_d = revoked_d | (own1 ? 2'b10 : 2'b01);
        end
      end
      DRAIN: begin
        if (bus.asmi_busy) begin
          settle_d = '0;
        end else if (({16'd0, settle_q} + 32'd1) >= SETTLE_CYCLES) begin
          state_d = IDLE;
        end else begin
          settle_d = sat_inc16(settle_q);
        end
      end
      default: state_d = IDLE;
    endcase

    case (state_d)
      OWN0:    gnt_d = 2'b01;
      OWN1:    gnt_d = 2'b10;
      default: gnt_d = 2'b00;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      idle_q    <= '0;
      settle_q  <= '0;
      last_q    <= 1'b1;
      revoked_q <= '0;
      tmo_q     <= '0;
      gnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      idle_q    <= idle_d;
      settle_q  <= settle_d;
      last_q    <= last_d;
      revoked_q <= revoked_d;
      tmo_q     <= tmo_d;
      gnt_q     <= gnt_d;
    end
  end

  // Owner strobes pass straight through so the flash sees them with no added latency.
  always_comb begin
    bus.asmi_addr   = '0;
    bus.asmi_cmd    = '0;
    bus.asmi_datain = '0;
    case (state_q)
      OWN0: begin
        bus.asmi_addr   = bus.c0_addr;
        bus.asmi_cmd    = bus.c0_cmd;
        bus.asmi_datain = bus.c0_datain;
      end
      OWN1: begin
        bus.asmi_addr = bus.c1_addr;
        bus.asmi_cmd  = bus.c1_cmd;
      end
      default: ;
    endcase
  end

  assign bus.gnt         = gnt_q;
  assign bus.timeout_err = tmo_q;
endmodule

// File: tb/tb_asmi_arbiter.sv
// Scoreboard bench for asmi_arbiter: each cycle's expected grant, timeout and ASMI bus
// values are queued when stimulus is applied and compared mid-cycle on the falling edge.
module tb_asmi_arbiter;
  logic clock   = 1'b0;
  logic reset_n = 1'b0;

  asmi_arbiter_if bus();

  asmi_arbiter #(.TIMEOUT_CYCLES(16), .SETTLE_CYCLES(2)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  always #5 clock = ~clock;

  typedef struct {
    string       tag;
    logic [1:0]  gnt;
    logic [1:0]  tmo;
    logic [5:0]  cmd;
    logic [23:0] addr;
    logic [7:0]  din;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Queue the expectation for the current cycle, compare on the falling edge, then
  // advance to just after the next rising edge where the next stimulus is applied.
  task automatic step(input string tag, input logic [1:0] g, input logic [1:0] t);
    exp_t e;
    e.tag  = tag;
    e.gnt  = g;
    e.tmo  = t;
    e.cmd  = '0;
    e.addr = '0;
    e.din  = '0;
    if (g == 2'b01) begin
      e.cmd  = bus.c0_cmd;
      e.addr = bus.c0_addr;
      e.din  = bus.c0_datain;
    end else if (g == 2'b10) begin
      e.cmd  = bus.c1_cmd;
      e.addr = bus.c1_addr;
    end
    sb.push_back(e);
    @(negedge clock);
    e = sb.pop_front();
    check_eq({e.tag, ".gnt"},  32'(bus.gnt),         32'(e.gnt));
    check_eq({e.tag, ".tmo"},  32'(bus.timeout_err), 32'(e.tmo));
    check_eq({e.tag, ".cmd"},  32'(bus.asmi_cmd),    32'(e.cmd));
    check_eq({e.tag, ".addr"}, 32'(bus.asmi_addr),   32'(e.addr));
    check_eq({e.tag, ".din"},  32'(bus.asmi_datain), 32'(e.din));
    @(posedge clock);
    #1;
  endtask

  initial begin
    bus.req       = 2'b00;
    bus.c0_addr   = 24'hFFFFFF;
    bus.c1_addr   = 24'hEEEEEE;
    bus.c0_cmd    = 6'h3F;
    bus.c1_cmd    = 6'h3F;
    bus.c0_datain = 8'hFF;
    bus.asmi_busy = 1'b1;
    step("reset", 2'b00, 2'b00);
    reset_n       = 1'b1;
    bus.c0_cmd    = '0;
    bus.c1_cmd    = '0;
    bus.asmi_busy = 1'b0;

    // Single client 0 request, sector erase passes through in the grant cycle
    bus.req = 2'b01;
    step("s1_idle", 2'b00, 2'b00);
    bus.c0_addr   = 24'h100000;
    bus.c0_cmd    = 6'b010000;
    bus.c0_datain = 8'hA5;
    bus.c1_cmd    = 6'b000001;
    bus.c1_addr   = 24'hABCDEF;
    step("s1_gnt", 2'b01, 2'b00);
    bus.c0_cmd = '0;
    step("s1_hold", 2'b01, 2'b00);
    bus.req = 2'b00;
    step("s1_rel", 2'b01, 2'b00);
    step("s1_dr1", 2'b00, 2'b00);
    step("s1_dr2", 2'b00, 2'b00);
    step("s1_idle2", 2'b00, 2'b00);

    // Both request from reset: client 0 first, handover through DRAIN, no pre-emption
    reset_n = 1'b0;
    step("rst2", 2'b00, 2'b00);
    reset_n = 1'b1;
    bus.req = 2'b11;
    step("s2_idle", 2'b00, 2'b00);
    bus.c0_cmd = 6'b100000;
    step("s2_g0", 2'b01, 2'b00);
    bus.c0_cmd = '0;
    bus.req    = 2'b10;
    step("s2_rel0", 2'b01, 2'b00);
    step("s2_dr1", 2'b00, 2'b00);
    step("s2_dr2", 2'b00, 2'b00);
    step("s2_idle2", 2'b00, 2'b00);
    bus.c1_addr = 24'h000123;
    step("s2_g1", 2'b10, 2'b00);
    bus.req = 2'b11;
    for (int i = 0; i < 3; i++) step("s2_nopre", 2'b10, 2'b00);
    bus.req = 2'b01;
    step("s2_rel1", 2'b10, 2'b00);
    bus.req = 2'b11;
    step("s2_dr3", 2'b00, 2'b00);
    step("s2_dr4", 2'b00, 2'b00);
    step("s2_idle3", 2'b00, 2'b00);
    step("s2_g0b", 2'b01, 2'b00);

    // Long busy in OWN0, then DRAIN waits for an unbroken settle window
    bus.c1_cmd    = '0;
    bus.asmi_busy = 1'b1;
    for (int i = 0; i < 1000; i++) step("s3_busy", 2'b01, 2'b00);
    bus.req = 2'b10;
    step("s3_rel", 2'b01, 2'b00);
    bus.req = 2'b11;
    for (int i = 0; i < 3; i++) step("s3_drbusy", 2'b00, 2'b00);
    bus.asmi_busy = 1'b0;
    step("s3_set1", 2'b00, 2'b00);
    bus.asmi_busy = 1'b1;
    step("s3_setclr", 2'b00, 2'b00);
    bus.asmi_busy = 1'b0;
    step("s3_set1b", 2'b00, 2'b00);
    step("s3_set2", 2'b00, 2'b00);
    step("s3_idle", 2'b00, 2'b00);
    bus.req = 2'b10;
    step("s3_g1rr", 2'b10, 2'b00);

    // Silent owner 1 is revoked after 16 idle cycles and stays locked out until req toggles
    for (int i = 0; i < 15; i++) step("s4_own", 2'b10, 2'b00);
    step("s4_tmo", 2'b00, 2'b10);
    for (int i = 0; i < 5; i++) step("s4_locked", 2'b00, 2'b00);
    bus.req = 2'b00;
    step("s4_toggle", 2'b00, 2'b00);
    bus.req = 2'b10;
    step("s4_rereq", 2'b00, 2'b00);
    bus.req = 2'b00;
    step("s4_regnt", 2'b10, 2'b00);

    // Release on the exact timeout cycle is a normal release
    bus.req = 2'b01;
    step("s5_dr1", 2'b00, 2'b00);
    step("s5_dr2", 2'b00, 2'b00);
    step("s5_idle", 2'b00, 2'b00);
    for (int i = 0; i < 15; i++) step("s5_own", 2'b01, 2'b00);
    bus.req = 2'b00;
    step("s5_relto", 2'b01, 2'b00);
    step("s5_notmo", 2'b00, 2'b00);
    bus.req = 2'b01;
    step("s5_dr3", 2'b00, 2'b00);
    step("s5_idle2", 2'b00, 2'b00);
    step("s5_regnt", 2'b01, 2'b00);

    // Asynchronous reset in the middle of a write, then fresh grant from IDLE
    bus.c0_cmd    = 6'b001000;
    bus.c0_addr   = 24'h002000;
    bus.c0_datain = 8'h5A;
    bus.asmi_busy = 1'b1;
    step("s6_write", 2'b01, 2'b00);
    reset_n = 1'b0;
    bus.req = 2'b10;
    step("s6_rst", 2'b00, 2'b00);
    step("s6_rsthold", 2'b00, 2'b00);
    reset_n = 1'b1;
    step("s6_idle", 2'b00, 2'b00);
    step("s6_g1", 2'b10, 2'b00);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
